// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - shared constants, state encoding and parity modes for the UART transmitter
package fifo_uart_tx_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY_BIT,
      STOP
   } state_t;

   // Counter width that stays at least one bit for degenerate sizes.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// rtl/fifo_uart_tx_baud_tick.sv - bit-period counter producing a one-cycle tick every DIVISOR cycles
module baud_tick
   import fifo_uart_tx_pkg::*;
#(
   parameter int DIVISOR = 16
)(
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int CW = cnt_width(DIVISOR);
   localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (restart || count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter fed by a strobe-driven upstream FIFO, with cts gating
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DATA_WIDTH = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_data_available,
   output logic                  receiver_ready,
   input  logic                  cts,
   output logic                  tx,
   output logic                  busy
);

   localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
   localparam int IDX_W   = cnt_width(DATA_WIDTH);
   localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

   state_t                state;
   logic [DATA_WIDTH-1:0] data;
   logic [IDX_W-1:0]      bit_idx;
   logic                  tick;
   logic                  capture;
   logic                  parity_bit;

   assign capture    = (state == IDLE) && receiver_ready && in_data_available;
   assign parity_bit = (PARITY == PARITY_ODD) ? ~^data : ^data;

   baud_tick #(
      .DIVISOR (DIVISOR)
   ) u_baud_tick (
      .clk     (clk),
      .reset   (reset),
      .restart (capture),
      .tick    (tick)
   );

   // bit_idx counts data bits, then is reused to count stop bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         data           <= '0;
         bit_idx        <= '0;
         tx             <= TRUE;
         busy           <= FALSE;
         receiver_ready <= FALSE;
      end else begin
         case (state)
            IDLE: begin
               if (capture) begin
                  data           <= in_data;
                  state          <= START;
                  tx             <= FALSE;
                  busy           <= TRUE;
                  receiver_ready <= FALSE;
               end else begin
                  tx             <= TRUE;
                  busy           <= FALSE;
                  receiver_ready <= cts;
               end
            end
            START: begin
               if (tick) begin
                  state <= DATA;
                  tx    <= data[0];
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_idx == LAST_DATA) begin
                     bit_idx <= '0;
                     if (PARITY != PARITY_NONE) begin
                        state <= PARITY_BIT;
                        tx    <= parity_bit;
                     end else begin
                        state <= STOP;
                        tx    <= TRUE;
                     end
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx      <= data[bit_idx + 1'b1];
                  end
               end
            end
            PARITY_BIT: begin
               if (tick) begin
                  state <= STOP;
                  tx    <= TRUE;
               end
            end
            STOP: begin
               if (tick) begin
                  if (bit_idx == LAST_STOP) begin
                     bit_idx        <= '0;
                     state          <= IDLE;
                     busy           <= FALSE;
                     receiver_ready <= cts;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx in 8N1, 8E2 and 8O1 configurations
module tb_fifo_uart_tx;

   localparam int DIV = 16;

   typedef struct {
      int         dut;
      logic [7:0] data;
      int         len;
      logic       chk_par;
      logic       par;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data [3];
   logic       strobe  [3];
   logic       cts     [3];
   logic       ready_w [3];
   logic       tx_w    [3];
   logic       busy_w  [3];

   int   par_of  [3] = '{0, 2, 1};
   int   stop_of [3] = '{1, 2, 1};
   int   n_checks = 0;
   int   n_errors = 0;
   vec_t vecs    [3];

   always #5 clk = ~clk;

   fifo_uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .reset(rst_n), .in_data(in_data[0]), .in_data_available(strobe[0]),
      .receiver_ready(ready_w[0]), .cts(cts[0]), .tx(tx_w[0]), .busy(busy_w[0]));

   fifo_uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(2)) u1 (
      .clk(clk), .reset(rst_n), .in_data(in_data[1]), .in_data_available(strobe[1]),
      .receiver_ready(ready_w[1]), .cts(cts[1]), .tx(tx_w[1]), .busy(busy_w[1]));

   fifo_uart_tx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) u2 (
      .clk(clk), .reset(rst_n), .in_data(in_data[2]), .in_data_available(strobe[2]),
      .receiver_ready(ready_w[2]), .cts(cts[2]), .tx(tx_w[2]), .busy(busy_w[2]));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, $signed(got), $signed(exp));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int frame_len(input int idx);
      return DIV * (1 + 8 + int'(par_of[idx] != 0) + stop_of[idx]);
   endfunction

   // Expected line level i cycles after the capture edge, from the frame layout.
   function automatic logic model_tx(input int idx, input logic [7:0] d, input int i);
      int b;
      b = i / DIV;
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (par_of[idx] != 0 && b == 9) return (par_of[idx] == 1) ? ~^d : ^d;
      return 1'b1;
   endfunction

   task automatic run_frame(input int idx, input logic [7:0] d, input int len, input int inject_at,
                            input string name, output logic par_seen, output int waited);
      int   bad_at;
      logic bad_busy;
      logic bad_ready;
      waited = 0;
      while (ready_w[idx] !== 1'b1 && waited < 500) begin
         step();
         waited++;
      end
      check({name, " ready before"}, 32'(ready_w[idx]), 32'd1);
      in_data[idx] = d;
      strobe[idx]  = 1'b1;
      step();
      strobe[idx] = 1'b0;
      bad_at    = -1;
      bad_busy  = 1'b0;
      bad_ready = 1'b0;
      par_seen  = 1'bx;
      for (int i = 0; i < len; i++) begin
         if (tx_w[idx] !== model_tx(idx, d, i) && bad_at < 0) bad_at = i;
         if (busy_w[idx] !== 1'b1) bad_busy = 1'b1;
         if (ready_w[idx] !== 1'b0) bad_ready = 1'b1;
         if (i == DIV * 9 + DIV / 2) par_seen = tx_w[idx];
         if (i == inject_at) begin
            in_data[idx] = 8'h3C;
            strobe[idx]  = 1'b1;
         end
         step();
         strobe[idx] = 1'b0;
      end
      check({name, " tx first wrong cycle"}, bad_at, -1);
      check({name, " busy dropped in frame"}, 32'(bad_busy), 32'd0);
      check({name, " ready high in frame"}, 32'(bad_ready), 32'd0);
      check({name, " busy after frame"}, 32'(busy_w[idx]), 32'd0);
      check({name, " tx after frame"}, 32'(tx_w[idx]), 32'd1);
      check({name, " ready after frame"}, 32'(ready_w[idx]), 32'(cts[idx]));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic       p;
      int         w;
      logic       flag;
      logic [7:0] d;
      int         idx;

      vecs[0] = '{0, 8'hA5, 160, 1'b0, 1'b0};
      vecs[1] = '{1, 8'h07, 192, 1'b1, 1'b1};
      vecs[2] = '{2, 8'h07, 176, 1'b1, 1'b0};

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data[i] = 8'h00;
         strobe[i]  = 1'b0;
         cts[i]     = 1'b1;
      end
      repeat (3) step();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset tx[%0d]", i), 32'(tx_w[i]), 32'd1);
         check($sformatf("reset busy[%0d]", i), 32'(busy_w[i]), 32'd0);
         check($sformatf("reset ready[%0d]", i), 32'(ready_w[i]), 32'd0);
      end
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 3; i++)
         check($sformatf("ready after release[%0d]", i), 32'(ready_w[i]), 32'd1);

      for (int v = 0; v < 3; v++) begin
         run_frame(vecs[v].dut, vecs[v].data, vecs[v].len, -1, $sformatf("vec%0d", v), p, w);
         if (vecs[v].chk_par) check($sformatf("vec%0d parity", v), 32'(p), 32'(vecs[v].par));
      end

      run_frame(0, 8'h00, 160, -1, "b2b first", p, w);
      run_frame(0, 8'hFF, 160, -1, "b2b second", p, w);
      check("b2b idle gap", w, 0);

      run_frame(0, 8'h01, 160, DIV * 3 + 5, "inject", p, w);
      flag = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) flag = 1'b1;
         step();
      end
      check("injected char sent", 32'(flag), 32'd0);

      cts[0] = 1'b0;
      step();
      check("cts low ready", 32'(ready_w[0]), 32'd0);
      flag = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (i == 5) begin
            in_data[0] = 8'h55;
            strobe[0]  = 1'b1;
         end else begin
            strobe[0] = 1'b0;
         end
         step();
         if (ready_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) flag = 1'b1;
      end
      strobe[0] = 1'b0;
      check("cts low stays idle", 32'(flag), 32'd0);
      cts[0] = 1'b1;
      step();
      check("cts high ready", 32'(ready_w[0]), 32'd1);

      in_data[0] = 8'hF7;
      strobe[0]  = 1'b1;
      step();
      strobe[0] = 1'b0;
      repeat (DIV * 4 + DIV / 2) step();
      check("pre-reset data bit3", 32'(tx_w[0]), 32'd0);
      #3 rst_n = 1'b0;
      #1;
      check("async reset tx", 32'(tx_w[0]), 32'd1);
      check("async reset busy", 32'(busy_w[0]), 32'd0);
      check("async reset ready", 32'(ready_w[0]), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      check("ready after mid reset", 32'(ready_w[0]), 32'd1);
      d = 8'($urandom);
      run_frame(0, d, 160, -1, "after reset", p, w);

      for (int k = 0; k < 9; k++) begin
         idx = int'($urandom_range(0, 2));
         d   = 8'($urandom);
         run_frame(idx, d, frame_len(idx), -1, $sformatf("rand%0d dut%0d data%02h", k, idx, d), p, w);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate in bit/s.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, character width in bits (5..9).
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bit count (1 or 2).
REQ-006 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-008 SHALL have port in_data  input  DATA_WIDTH  character offered by the upstream FIFO.
REQ-009 SHALL have port in_data_available  input  1  one-cycle strobe; in_data valid in that cycle.
REQ-010 SHALL have port receiver_ready  output  1  registered; high = block will accept one character.
REQ-011 SHALL have port cts  input  1  clear-to-send, active high, already synchronised.
REQ-012 SHALL have port tx  output  1  registered serial line, idle high.
REQ-013 SHALL have port busy  output  1  registered; high while any frame bit is on tx.

Function
REQ-014 SHALL use bit period DIVISOR = CLK_FREQ/BAUD_RATE clock cycles (integer division), counter width $clog2(DIVISOR).
REQ-015 SHALL implement states IDLE, START, DATA, PARITY_BIT, STOP.
REQ-016 SHALL drive receiver_ready high only in IDLE with cts high and no strobe captured this cycle.
REQ-017 SHALL, on a rising edge in IDLE with in_data_available high, latch in_data, clear receiver_ready and enter START in the same edge.
REQ-018 SHALL hold receiver_ready low from the edge capturing a strobe until the frame's last stop bit completes, so the upstream FIFO (which re-samples ready two cycles after a strobe) never issues a second strobe mid-frame.
REQ-019 SHALL ignore in_data_available in any state other than IDLE, and in IDLE while receiver_ready is low; ignored characters are dropped, not queued.
REQ-020 SHALL drive tx low for exactly DIVISOR cycles in START, starting the cycle after capture (capture-to-start-bit latency 1 cycle).
REQ-021 SHALL send DATA_WIDTH data bits LSB first, each DIVISOR cycles, bit index counter wrapping to 0 on leaving DATA.
REQ-022 SHALL, when PARITY != 0, send one parity bit after the data: odd = XNOR-reduce of the data, even = XOR-reduce; PARITY == 0 skips PARITY_BIT.
REQ-023 SHALL drive tx high for STOP_BITS*DIVISOR cycles in STOP, then return to IDLE.
REQ-024 SHALL deassert busy on the edge that enters IDLE; receiver_ready may rise on that same edge if cts is high.
REQ-025 SHALL not abort a frame when cts falls mid-frame; cts gates only the acceptance of the next character.
REQ-026 SHALL keep total frame length 1+DATA_WIDTH+(PARITY!=0)+STOP_BITS bit periods, no extra idle cycle beyond the IDLE re-entry cycle.

Reset
REQ-027 SHALL, while reset is low, force state IDLE, tx=1, busy=0, receiver_ready=0, baud and bit counters 0, data latch 0, independent of clk.
REQ-028 SHALL, on reset assertion mid-frame, release tx high immediately and discard the frame in progress.
REQ-029 SHALL raise receiver_ready on the first rising edge after reset deasserts when cts is high.

Structure
REQ-030 SHALL take TRUE/FALSE from the shared constants include; state encodings and parity-mode constants (PARITY_NONE/ODD/EVEN) SHALL live in the same shared constants file.
REQ-031 SHALL instantiate one sub-module baud_tick (parameter DIVISOR, inputs clk, reset, restart; output one-cycle tick) for bit timing, restarted on capture.

Verification
REQ-032 SHALL check with CLK_FREQ=16, BAUD_RATE=1, 8N1: strobe 8'hA5 in IDLE -> tx low 16 cycles from capture+1, then bits 1,0,1,0,0,1,0,1 each 16 cycles, high 16 cycles, busy low after 160 cycles.
REQ-033 SHALL check back-to-back via the upstream FIFO with 8'h00 then 8'hFF queued -> receiver_ready low between frames, second start bit begins exactly 1 cycle after first frame's stop ends.
REQ-034 SHALL check strobe injected mid-frame (8'h3C during DATA of 8'h01) -> tx waveform of 8'h01 unchanged, 8'h3C never transmitted.
REQ-035 SHALL check cts held low, FIFO non-empty -> receiver_ready stays 0, tx stays 1; cts raised -> receiver_ready 1 next edge.
REQ-036 SHALL check PARITY=2, STOP_BITS=2, data 8'h07 -> parity bit 1, tx high 32 cycles at stop; PARITY=1 same data -> parity bit 0.
REQ-037 SHALL check reset asserted at the 4th data bit -> tx=1, busy=0, receiver_ready=0 asynchronously; after release, next strobe transmits normally.
